// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO and its serial transmitter.
//   FIFO_DATA_W : FIFO word width
//   tx_state_t  : transmitter FSM states
//   word_t      : one FIFO word
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

    typedef logic [FIFO_DATA_W-1:0] word_t;

endpackage : fifo_pkg

// File: rtl/fifo_serial_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Free-running divider that marks the last clk cycle of each serial bit.
//   clk      : system clock
//   rst_     : asynchronous active-low reset
//   clear    : synchronous clear of the count (held while no bit is on the line)
//   bit_done : high while count == CLKS_PER_BIT-1; the count wraps to 0 after it
// -----------------------------------------------------------------------------
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_,
    input  logic clear,
    output logic bit_done
);

    // A single-cycle bit still needs a 1-bit counter to keep the code uniform.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_done = (count == LAST);

endmodule : bit_timer

// File: rtl/fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// fifo_serial_tx
// Pops words from a FIFO and sends each as a framed serial stream:
// start bit (0), DATA_W data bits MSB-first, stop bit (1).
//   clk           : system clock
//   rst_          : asynchronous active-low reset
//   enable        : permits starting new frames
//   fifo_empty    : FIFO empty flag
//   fifo_data_out : FIFO read data, valid the edge after a pop
//   fifo_read     : pop request, high only in POP
//   tx_serial     : registered serial line, idles high
//   busy          : high in every state except IDLE
//   word_count    : completed frames, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fifo_serial_tx
    import fifo_pkg::*;
#(
    parameter int DATA_W       = FIFO_DATA_W,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_read,
    output logic              tx_serial,
    output logic              busy,
    output logic [15:0]       word_count
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_t         state;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  bit_idx;
    logic              bit_done;
    logic              timer_clear;

    // The timer only runs while a bit is on the line, so every START begins
    // from a zero count.
    assign timer_clear = (state == IDLE) || (state == POP) || (state == LOAD);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_    (rst_),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    assign fifo_read = (state == POP);
    assign busy      = (state != IDLE);

    // tx_serial is assigned the value belonging to the state being entered,
    // so the line changes exactly on the edge that enters that state.
    // NOTE: the shift register and index are datapath-only but still reset,
    // so an aborted frame leaves no stale word behind.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            tx_serial  <= 1'b1;
            word_count <= '0;
            shift_reg  <= '0;
            bit_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    if (enable && !fifo_empty) begin
                        state <= POP;
                    end
                end

                POP: begin
                    tx_serial <= 1'b1;
                    state     <= LOAD;
                end

                LOAD: begin
                    shift_reg <= fifo_data_out;
                    tx_serial <= 1'b0;
                    state     <= START;
                end

                START: begin
                    if (bit_done) begin
                        bit_idx   <= IDX_W'(DATA_W - 1);
                        tx_serial <= shift_reg[DATA_W-1];
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        shift_reg <= shift_reg << 1;
                        if (bit_idx == '0) begin
                            tx_serial <= 1'b1;
                            state     <= STOP;
                        end else begin
                            bit_idx   <= bit_idx - IDX_W'(1);
                            // Next bit is the MSB after this shift.
                            tx_serial <= shift_reg[DATA_W-2];
                        end
                    end
                end

                STOP: begin
                    tx_serial <= 1'b1;
                    if (bit_done) begin
                        word_count <= word_count + 16'd1;
                        state      <= (enable && !fifo_empty) ? POP : IDLE;
                    end
                end

                default: begin
                    tx_serial <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : fifo_serial_tx

// File: tb/tb_fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_serial_tx
// Directed bench for fifo_serial_tx: a default instance fed by a small FIFO
// model, plus a CLKS_PER_BIT=1 instance driven directly.
// -----------------------------------------------------------------------------
module tb_fifo_serial_tx;
    import fifo_pkg::*;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        enable = 1'b0;
    logic        fifo_empty;
    word_t       fifo_data_out = '0;
    logic        fifo_read, tx_serial, busy;
    logic [15:0] word_count;

    // CLKS_PER_BIT = 1 instance
    logic        en1 = 1'b0;
    logic        empty1 = 1'b1;
    word_t       data1 = 16'hC0DE;
    logic        read1, tx1, busy1;
    logic [15:0] wc1;

    fifo_serial_tx dut (
        .clk          (clk),
        .rst_         (rst_),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_read    (fifo_read),
        .tx_serial    (tx_serial),
        .busy         (busy),
        .word_count   (word_count)
    );

    fifo_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk          (clk),
        .rst_         (rst_),
        .enable       (en1),
        .fifo_empty   (empty1),
        .fifo_data_out(data1),
        .fifo_read    (read1),
        .tx_serial    (tx1),
        .busy         (busy1),
        .word_count   (wc1)
    );

    // FIFO model: pushes from the stimulus, pops on accepted fifo_read.
    word_t mem [16];
    int    wr_ptr = 0;
    int    rd_ptr = 0;
    int    pops   = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_read && !fifo_empty) begin
            fifo_data_out <= mem[rd_ptr[3:0]];
            rd_ptr        <= rd_ptr + 1;
            pops          <= pops + 1;
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input word_t w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_ = 1'b0;
        cyc(1);
        rst_ = 1'b1;
    endtask

    // Expected line for one default frame: 18 bits, 4 samples each.
    function automatic logic [71:0] expand(input word_t w);
        logic [17:0] f;
        logic [71:0] e;
        f = {1'b0, w, 1'b1};
        e = '0;
        for (int b = 0; b < 18; b++)
            for (int k = 0; k < 4; k++)
                e[71 - 4*b - k] = f[17 - b];
        return e;
    endfunction

    // Waits (bounded) for the start bit, counting idle-high cycles first,
    // then records the 72 line samples. Optionally drops enable or asserts
    // reset at a given sample index inside the frame.
    task automatic frame(input string tag, input word_t w, input int exp_gap,
                         input int drop_at, input int abort_at);
        int          gap;
        logic [71:0] obs;
        gap = 0;
        obs = '0;
        cyc(1);
        while (tx_serial === 1'b1 && gap < 300) begin
            gap++;
            cyc(1);
        end
        check({tag, " gap"}, 72'(gap), 72'(exp_gap));
        if (gap >= 300) return;
        for (int i = 0; i < 72; i++) begin
            if (i == abort_at) begin
                rst_ = 1'b0;
                #1;
                check({tag, " async reset tx/busy/read"},
                      72'({tx_serial, busy, fifo_read}), 72'(3'b100));
                check({tag, " async reset word_count"}, 72'(word_count), 72'(0));
                return;
            end
            if (i == drop_at) enable = 1'b0;
            obs[71 - i] = tx_serial;
            if (i < 71) cyc(1);
        end
        check({tag, " bits"}, obs, expand(w));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [17:0] obs1;

        // Reset held with a word waiting and enable high.
        rst_ = 1'b0;
        enable = 1'b1;
        push(16'hA5C3);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("reset tx/busy/read/wc", 72'({tx_serial, busy, fifo_read, word_count}),
                  72'({1'b1, 1'b0, 1'b0, 16'h0000}));
        end
        check("reset dut1 tx/busy", 72'({tx1, busy1, wc1}), 72'({1'b1, 1'b0, 16'h0000}));
        rst_ = 1'b1;
        cyc(1);
        check("pop pulse high", 72'(fifo_read), 72'(1));
        cyc(1);
        check("pop pulse low", 72'(fifo_read), 72'(0));

        // Single word A5C3 (pop and load already observed above).
        frame("single", 16'hA5C3, 0, -1, -1);
        cyc(1);
        check("single end busy/wc/tx", 72'({busy, word_count, tx_serial}),
              72'({1'b0, 16'd1, 1'b1}));
        check("single pops", 72'(pops), 72'(1));

        // Back-to-back frames.
        reset_pulse();
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        frame("b2b w1", 16'h0001, 2, -1, -1);
        frame("b2b w2", 16'h0002, 2, -1, -1);
        frame("b2b w3", 16'h0003, 2, -1, -1);
        cyc(1);
        check("b2b end busy/wc", 72'({busy, word_count}), 72'({1'b0, 16'd3}));
        cyc(5);
        check("b2b idle busy/read", 72'({busy, fifo_read}), 72'(0));
        check("b2b pops", 72'(pops), 72'(4));

        // Enable dropped during DATA of the first frame.
        reset_pulse();
        push(16'h1234);
        push(16'h8000);
        frame("endrop w1", 16'h1234, 2, 20, -1);
        cyc(1);
        check("endrop end busy/wc", 72'({busy, word_count}), 72'({1'b0, 16'd1}));
        cyc(8);
        check("endrop held busy", 72'(busy), 72'(0));
        check("endrop pops", 72'(pops), 72'(5));
        check("endrop queued", 72'(wr_ptr - rd_ptr), 72'(1));
        enable = 1'b1;
        frame("endrop w2", 16'h8000, 2, -1, -1);
        cyc(1);
        check("endrop w2 wc", 72'({busy, word_count}), 72'({1'b0, 16'd2}));

        // Reset at cycle 30 of a frame; the popped word is not resent.
        push(16'hBEEF);
        push(16'h0F0F);
        frame("abort", 16'hBEEF, 2, -1, 30);
        cyc(2);
        rst_ = 1'b1;
        frame("post-abort", 16'h0F0F, 2, -1, -1);
        cyc(1);
        check("post-abort wc/busy", 72'({busy, word_count}), 72'({1'b0, 16'd1}));
        check("post-abort pops", 72'(pops), 72'(8));
        check("post-abort empty", 72'(fifo_empty), 72'(1));

        // word_count wrap from 0xFFFF.
        force dut.word_count = 16'hFFFF;
        #1;
        release dut.word_count;
        push(16'h7E81);
        frame("wrap", 16'h7E81, 2, -1, -1);
        cyc(1);
        check("wrap wc", 72'({busy, word_count}), 72'({1'b0, 16'h0000}));

        // CLKS_PER_BIT = 1: 18-cycle frame.
        en1 = 1'b1;
        empty1 = 1'b0;
        cyc(1);
        check("cpb1 pop", 72'(read1), 72'(1));
        empty1 = 1'b1;
        cyc(2);
        n = 0;
        obs1 = '0;
        while (busy1 && n < 100) begin
            if (n < 18) obs1[17 - n] = tx1;
            n++;
            cyc(1);
        end
        check("cpb1 length", 72'(n), 72'(18));
        check("cpb1 bits", 72'(obs1), 72'({1'b0, 16'hC0DE, 1'b1}));
        check("cpb1 wc", 72'(wc1), 72'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fifo_serial_tx

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Downstream consumer of the 16-bit FIFO. When enabled and the FIFO is not empty, it pops one word and transmits it on a single serial line as a framed bit stream: one start bit (0), 16 data bits MSB-first, and one stop bit (1). It repeats until the FIFO is empty or the block is disabled. It connects directly to the FIFO ports fifo_read, fifo_data_out and fifo_empty.

Parameters:
DATA_W, 16, word width; must match the FIFO data width.
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range is 1 to 65535.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_  in  1  asynchronous, active-low reset.
enable  in  1  permits starting new frames.
fifo_empty  in  1  FIFO empty flag.
fifo_data_out  in  DATA_W  FIFO read data. Valid from the clk edge at which a pop is accepted until the next pop.
fifo_read  out  1  pop request to the FIFO; combinational from state.
tx_serial  out  1  serial line; idles high.
busy  out  1  high in every state except IDLE.
word_count  out  16  number of frames completed; wraps modulo 2^16.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Assertion immediately forces: state=IDLE, tx_serial=1, busy=0, fifo_read=0, word_count=0, shift register=0, bit timer=0, bit index=0.
  - A frame in progress is abandoned. The popped word is discarded and not re-read.
- FIFO contract: a pop happens at a clk edge where fifo_read=1 and fifo_empty=0. The popped word appears on fifo_data_out after that edge and is captured on the following edge.
- IDLE:
  - tx_serial=1.
  - If enable=1 and fifo_empty=0, go to POP on the next edge. Otherwise stay in IDLE.
- POP:
  - fifo_read=1 for exactly this one cycle.
  - Go to LOAD.
  - fifo_empty is not re-checked in POP; entry is only from a non-empty check.
- LOAD:
  - Shift register <= fifo_data_out.
  - Bit timer cleared.
  - Go to START.
- START:
  - tx_serial=0 for CLKS_PER_BIT cycles.
  - Then go to DATA with bit index=DATA_W-1.
- DATA:
  - tx_serial = shift register MSB. Each bit is held CLKS_PER_BIT cycles.
  - At the end of each bit: shift left by 1, decrement the index.
  - After bit 0, go to STOP.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - On the final cycle, word_count increments by 1 (wraps 0xFFFF -> 0x0000).
  - Next state: POP if enable=1 and fifo_empty=0, otherwise IDLE.
- Frame timing:
  - Frame length is (DATA_W+2)*CLKS_PER_BIT cycles; 72 at defaults.
  - Back-to-back frames are separated by exactly 2 cycles of tx_serial=1 (the POP and LOAD cycles).
- Enable:
  - Sampled only in IDLE and on the final STOP cycle.
  - Deasserting enable mid-frame finishes the current frame, then stops.
- fifo_empty:
  - Sampled only at the same decision points as enable.
  - Writes into the FIFO during a frame have no effect until the next decision point.
- Bit timer: counts 0..CLKS_PER_BIT-1; the bit ends when timer==CLKS_PER_BIT-1. With CLKS_PER_BIT=1, every cycle is one bit.
- tx_serial is registered (glitch-free). Its value for each state takes effect from the edge that enters that state.
- Unreachable state encodings return to IDLE with tx_serial=1.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DATA_W=16.
  - Typedef tx_state_t: enum {IDLE, POP, LOAD, START, DATA, STOP}.
  - Typedef word_t = logic [FIFO_DATA_W-1:0].
- One sub-module, bit_timer:
  - Parameterised by CLKS_PER_BIT.
  - Inputs clk, rst_, clear. Output bit_done, asserted when count==CLKS_PER_BIT-1; the count self-wraps.

Test Plan:
- Reset behaviour: hold rst_=0 with enable=1 and fifo_empty=0 -> tx_serial=1, busy=0, fifo_read=0, word_count=0 throughout. After release, fifo_read pulses exactly 1 cycle on the second edge.
- Single word: with defaults, one word 16'hA5C3, then fifo_empty=1 -> tx_serial is 0 for 4 cycles, then bits 1010010111000011 at 4 cycles each, then 1 for 4 cycles. Then word_count=1 and busy=0 after 72+2 cycles.
- Back-to-back words: FIFO holds 16'h0001, 16'h0002, 16'h0003 -> three frames, each separated by exactly 2 high cycles. Exactly 3 fifo_read pulses; word_count=3; ends in IDLE.
- Enable dropped mid-frame: enable=0 during DATA of frame 1 with 2 words queued -> frame 1 completes and no further pop occurs (the queued word stays in the FIFO). word_count=1. Re-asserting enable sends word 2.
- Reset mid-frame: rst_=0 at cycle 30 of a frame -> tx_serial=1 immediately (asynchronous, before the next edge), word_count=0. After release the next FIFO word is transmitted and the aborted word is not retransmitted.
- Counter wrap: force word_count to 16'hFFFF, then send 1 frame -> word_count=16'h0000. Also repeat with CLKS_PER_BIT=1 -> frame length is 18 cycles.
